// File: rtl/vram_cmd_drain_if.sv
// vram_cmd_drain_if: FIFO read port and VRAM write port of the command drain.
//  master (drain side): drives fifo_rd, mem_addr, mem_wdata, mem_we;
//                       samples fifo_valid, fifo_empty, fifo_dout, mem_ready.
//  slave  (FIFO / arbiter side): the mirror image.
interface vram_cmd_drain_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              fifo_valid;
    logic              fifo_empty;
    logic [15:0]       fifo_dout;
    logic              fifo_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic              mem_ready;

    modport master (
        input  fifo_valid, fifo_empty, fifo_dout, mem_ready,
        output fifo_rd, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output fifo_valid, fifo_empty, fifo_dout, mem_ready,
        input  fifo_rd, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/vram_cmd_drain.sv
// vram_cmd_drain: pops 16-bit words from the host command FIFO, parses them
// into NOP / WRITE / FILL packets and issues VRAM word writes.
//  rclk   : single clock
//  RESET  : synchronous active-high reset, drops any partial packet
//  bus    : master side of vram_cmd_drain_if (FIFO pop port + VRAM write port)
//  busy   : high while a packet is being processed or a pop is in flight
//  err    : sticky illegal-opcode flag, cleared only by RESET
// ADDR_W must exceed 16 (the address-high word supplies bits ADDR_W-1:16).
module vram_cmd_drain #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                   rclk,
    input  logic                   RESET,
    vram_cmd_drain_if.master       bus,
    output logic                   busy,
    output logic                   err
);
    localparam int unsigned REM_W = 13;
    localparam int unsigned AHI_W = ADDR_W - 16;
    localparam logic [2:0]  LAT_LAST = 3'(RD_LAT);
    localparam logic [3:0]  OP_NOP   = 4'h0;
    localparam logic [3:0]  OP_WRITE = 4'h1;
    localparam logic [3:0]  OP_FILL  = 4'h2;

    typedef enum logic [2:0] {
        S_HDR = 3'd0,
        S_AHI = 3'd1,
        S_ALO = 3'd2,
        S_DAT = 3'd3,
        S_MEM = 3'd4
    } state_t;

    state_t             state;
    logic               fetch_pend;
    logic [2:0]         lat_cnt;
    logic               fifo_rd_q;
    logic [3:0]         op_q;
    logic [REM_W-1:0]   remaining;
    logic [ADDR_W-1:0]  addr_q;
    logic [15:0]        wdata_q;
    logic               mem_we_q;
    logic               capture_c;
    logic               fetch_state_c;
    logic               unused_fifo_empty;

    // fifo_empty is informational only; pops are gated by fifo_valid.
    assign unused_fifo_empty = bus.fifo_empty;

    assign fetch_state_c = (state != S_MEM);
    // Popped word is on fifo_dout on the RD_LAT-th edge after the pop edge.
    assign capture_c     = fetch_pend && !fifo_rd_q && (lat_cnt == LAT_LAST);

    assign bus.fifo_rd   = fifo_rd_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = mem_we_q;

    // Fetch engine and packet FSM share one register process.
    always_ff @(posedge rclk) begin
        if (RESET) begin
            state      <= S_HDR;
            fetch_pend <= 1'b0;
            lat_cnt    <= 3'd0;
            fifo_rd_q  <= 1'b0;
            op_q       <= OP_NOP;
            remaining  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_we_q   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // One pop outstanding at a time: pulse, then count RD_LAT edges.
            if (fetch_state_c) begin
                if (fifo_rd_q) begin
                    fifo_rd_q <= 1'b0;
                    lat_cnt   <= 3'd1;
                end else if (fetch_pend) begin
                    if (lat_cnt == LAT_LAST) begin
                        fetch_pend <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end else if (bus.fifo_valid) begin
                    fifo_rd_q  <= 1'b1;
                    fetch_pend <= 1'b1;
                    busy       <= 1'b1;
                end
            end

            case (state)
                S_HDR: begin
                    if (capture_c) begin
                        case (bus.fifo_dout[15:12])
                            OP_NOP: begin
                                busy <= 1'b0;
                            end
                            OP_WRITE, OP_FILL: begin
                                op_q      <= bus.fifo_dout[15:12];
                                remaining <= (bus.fifo_dout[11:0] == 12'd0)
                                             ? 13'd4096
                                             : REM_W'(bus.fifo_dout[11:0]);
                                state     <= S_AHI;
                            end
                            default: begin
                                err  <= 1'b1;
                                busy <= 1'b0;
                            end
                        endcase
                    end
                end
                S_AHI: begin
                    if (capture_c) begin
                        addr_q[ADDR_W-1:16] <= bus.fifo_dout[AHI_W-1:0];
                        state               <= S_ALO;
                    end
                end
                S_ALO: begin
                    if (capture_c) begin
                        addr_q[15:0] <= bus.fifo_dout;
                        state        <= S_DAT;
                    end
                end
                S_DAT: begin
                    if (capture_c) begin
                        wdata_q  <= bus.fifo_dout;
                        mem_we_q <= 1'b1;
                        state    <= S_MEM;
                    end
                end
                S_MEM: begin
                    // Address/data stay put until the arbiter accepts.
                    if (bus.mem_ready) begin
                        addr_q    <= addr_q + ADDR_W'(1);
                        remaining <= remaining - REM_W'(1);
                        if (remaining == REM_W'(1)) begin
                            state    <= S_HDR;
                            mem_we_q <= 1'b0;
                            busy     <= 1'b0;
                        end else if (op_q == OP_WRITE) begin
                            state    <= S_DAT;
                            mem_we_q <= 1'b0;
                        end
                        // FILL: stay in S_MEM re-writing the latched word.
                    end
                end
                default: begin
                    state <= S_HDR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vram_cmd_drain.sv
// tb_vram_cmd_drain: scoreboard bench for vram_cmd_drain with a queue-based
// FIFO model (RD_LAT read latency) and a randomly back-pressuring arbiter.
module tb_vram_cmd_drain;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned RD_LAT = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic rclk = 1'b0;
    logic RESET;
    logic busy;
    logic err;

    vram_cmd_drain_if #(.ADDR_W(ADDR_W)) bus ();

    vram_cmd_drain #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .rclk  (rclk),
        .RESET (RESET),
        .bus   (bus.master),
        .busy  (busy),
        .err   (err)
    );

    always #5 rclk = ~rclk;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [15:0] fq[$];
    int          rd_idx = 0;
    int          pops = 0;
    logic [15:0] pipe [RD_LAT];
    int          ready_pct = 100;
    int          acc_cnt = 0;
    int          cyc = 0;
    int          acc_cyc_q[$];
    logic        exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // FIFO model: word popped on edge E appears on fifo_dout from edge E+RD_LAT-1.
    always @(posedge rclk) begin
        if (RESET) begin
            rd_idx <= fq.size();
            bus.fifo_valid <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= 16'h0;
        end else begin
            if (bus.fifo_rd) begin
                pipe[0] <= (rd_idx < fq.size()) ? fq[rd_idx] : 16'hDEAD;
                rd_idx  <= rd_idx + 1;
                pops    <= pops + 1;
            end else begin
                pipe[0] <= 16'hDEAD;
            end
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
            bus.fifo_valid <= (rd_idx + (bus.fifo_rd ? 1 : 0)) < fq.size();
        end
    end

    assign bus.fifo_dout  = pipe[RD_LAT-1];
    assign bus.fifo_empty = ~bus.fifo_valid;

    // Arbiter model: random accept with probability ready_pct.
    always @(posedge rclk) begin
        #1;
        bus.mem_ready = (int'($urandom_range(99)) < ready_pct);
    end

    // Monitor: scoreboard pop on every accepted write, hold-stability check.
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [15:0]       prev_data;
    wr_t               mon_e;

    always @(negedge rclk) begin
        cyc++;
        if (RESET) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (bus.fifo_rd)
                check("pop_with_data", 32'(rd_idx < fq.size()), 32'd1);
            if (bus.mem_we && prev_stall) begin
                check("hold_addr", 32'(bus.mem_addr), 32'(prev_addr));
                check("hold_data", 32'(bus.mem_wdata), 32'(prev_data));
            end
            if (bus.mem_we && bus.mem_ready) begin
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                    check("wr_data", 32'(bus.mem_wdata), 32'(mon_e.data));
                end
                acc_cnt++;
                acc_cyc_q.push_back(cyc);
            end
            prev_stall = bus.mem_we && !bus.mem_ready;
            prev_addr  = bus.mem_addr;
            prev_data  = bus.mem_wdata;
        end
    end

    task automatic push_word(input logic [15:0] w);
        fq.push_back(w);
    endtask

    // Reference model: expected writes follow directly from the packet rules.
    task automatic send_pkt(input logic [3:0] op, input logic [11:0] cnt,
                            input logic [ADDR_W-1:0] addr, input logic [15:0] data[$],
                            input logic [11:0] hi_junk);
        int  n;
        wr_t w;
        n = (cnt == 12'd0) ? 4096 : int'(cnt);
        push_word({op, cnt});
        if (op == 4'h1 || op == 4'h2) begin
            push_word({hi_junk, addr[ADDR_W-1:16]});
            push_word(addr[15:0]);
            foreach (data[i]) push_word(data[i]);
            for (int i = 0; i < n; i++) begin
                w.addr = ADDR_W'(int'(addr) + i);
                w.data = (op == 4'h1) ? data[i] : data[0];
                exp_q.push_back(w);
            end
        end else if (op != 4'h0) begin
            exp_err = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !busy && rd_idx == fq.size() && !bus.mem_we)
               && n < budget) begin
            @(negedge rclk);
            n++;
        end
        check({name, "_idle"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d[$];
        logic [15:0] none[$];
        int p0, a0, n, r, cnt;
        logic [3:0] op;
        logic [ADDR_W-1:0] addr;

        RESET = 1'b1;
        repeat (3) @(negedge rclk);
        check("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        RESET = 1'b0;
        @(negedge rclk);

        // 1: three-word WRITE at 0x12000
        p0 = pops;
        d = {16'hAAAA, 16'hBBBB, 16'hCCCC};
        send_pkt(4'h1, 12'd3, 20'h12000, d, 12'h000);
        wait_idle("t1", 300);
        check("t1_pops", 32'(pops - p0), 32'd6);
        check("t1_busy", 32'(busy), 32'd0);

        // 2: FILL cnt=0 -> 4096 back-to-back writes
        p0 = pops;
        a0 = acc_cnt;
        d = {16'h5555};
        send_pkt(4'h2, 12'd0, 20'h00010, d, 12'h000);
        wait_idle("t2", 6000);
        check("t2_pops", 32'(pops - p0), 32'd4);
        check("t2_count", 32'(acc_cnt - a0), 32'd4096);
        if (acc_cyc_q.size() >= a0 + 4096)
            check("t2_b2b", 32'(acc_cyc_q[a0+4095] - acc_cyc_q[a0]), 32'd4095);

        // 3: address wrap under backpressure
        ready_pct = 0;
        d = {16'h1234, 16'h5678};
        send_pkt(4'h1, 12'd2, 20'hFFFFF, d, 12'h000);
        n = 0;
        while (!bus.mem_we && n < 200) begin
            @(negedge rclk);
            n++;
        end
        check("t3_we_seen", 32'(n < 200), 32'd1);
        repeat (3) @(negedge rclk);
        check("t3_stall_we", 32'(bus.mem_we), 32'd1);
        check("t3_stall_addr", 32'(bus.mem_addr), 32'hFFFFF);
        check("t3_stall_data", 32'(bus.mem_wdata), 32'h1234);
        ready_pct = 100;
        wait_idle("t3", 300);

        // 4: illegal op, NOP, then a 1-word WRITE
        p0 = pops;
        send_pkt(4'h7, 12'h123, '0, none, 12'h000);
        send_pkt(4'h0, 12'h000, '0, none, 12'h000);
        d = {16'hBEEF};
        send_pkt(4'h1, 12'd1, 20'h00ABC, d, 12'h000);
        wait_idle("t4", 300);
        check("t4_err", 32'(err), 32'd1);
        check("t4_pops", 32'(pops - p0), 32'd6);

        // 5: starvation mid-packet
        p0 = pops;
        a0 = acc_cnt;
        d = {16'h9999};
        send_pkt(4'h1, 12'd1, 20'h00004, d, 12'h000);
        void'(fq.pop_back());
        void'(fq.pop_back());
        n = 0;
        while (rd_idx != fq.size() && n < 100) begin
            @(negedge rclk);
            n++;
        end
        check("t5_drained", 32'(n < 100), 32'd1);
        repeat (20) @(negedge rclk);
        check("t5_pops", 32'(pops - p0), 32'd2);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_no_rd", 32'(bus.fifo_rd), 32'd0);
        check("t5_no_write", 32'(acc_cnt - a0), 32'd0);
        push_word(16'h0004);
        push_word(16'h9999);
        wait_idle("t5", 300);
        check("t5_err_sticky", 32'(err), 32'd1);

        // random packets under random backpressure
        ready_pct = 60;
        for (int k = 0; k < 12; k++) begin
            r = int'($urandom_range(9));
            addr = ($urandom_range(3) == 0) ? ADDR_W'(20'hFFFFC + $urandom_range(3))
                                            : ADDR_W'($urandom);
            if (r == 0) begin
                op = 4'h0;
                cnt = int'($urandom_range(4095));
            end else if (r == 1) begin
                op = 4'($urandom_range(15, 3));
                cnt = int'($urandom_range(4095));
            end else if (r < 6) begin
                op = 4'h1;
                cnt = int'($urandom_range(6, 1));
            end else begin
                op = 4'h2;
                cnt = int'($urandom_range(8, 1));
            end
            d.delete();
            if (op == 4'h1) begin
                for (int i = 0; i < cnt; i++) d.push_back(16'($urandom));
            end else begin
                d.push_back(16'($urandom));
            end
            send_pkt(op, 12'(cnt), addr, d, 12'($urandom));
        end
        wait_idle("rand", 4000);
        check("rand_err", 32'(err), 32'(exp_err));

        // 6: RESET in the middle of a FILL
        ready_pct = 100;
        a0 = acc_cnt;
        d = {16'h7777};
        send_pkt(4'h2, 12'd0, 20'h00100, d, 12'h000);
        n = 0;
        while (acc_cnt < a0 + 10 && n < 300) begin
            @(negedge rclk);
            n++;
        end
        check("t6_ten_writes", 32'(n < 300), 32'd1);
        @(posedge rclk);
        #2;
        RESET = 1'b1;
        @(posedge rclk);
        @(negedge rclk);
        check("t6_mem_we", 32'(bus.mem_we), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        check("t6_mem_addr", 32'(bus.mem_addr), 32'd0);
        exp_err = 1'b0;
        RESET = 1'b0;
        @(negedge rclk);
        d = {16'h1111, 16'h2222};
        send_pkt(4'h1, 12'd2, 20'h00003, d, 12'h000);
        wait_idle("t6", 300);
        check("t6_err_after", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
